// File: rtl/a2d_spi_intf.sv
// SPI master for an 8-channel 12-bit A2D: one mux-setting frame, a fixed gap,
// then a sampling frame whose low 12 bits become the result.
module a2d_spi_intf #(
    parameter int unsigned DIV_W    = 5,
    parameter int unsigned GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned RES_W   = 12;
    localparam int unsigned BCNT_W  = 5;
    localparam int unsigned GAP_W   = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(1) << (DIV_W - 1);
    localparam logic [DIV_W-1:0]  DIV_RISE  = DIV_HALF - DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = '1;
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_W);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TXN1 = 3'd1,
        GAP  = 3'd2,
        TXN2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [DIV_W-1:0]     div, div_nxt;
    logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
    logic [GAP_W-1:0]     gap_cnt, gap_nxt;
    logic [FRAME_W-1:0]   shift, shift_nxt;
    logic [2:0]           chnnl_q, chnnl_nxt;
    logic                 ss_n_nxt;
    logic                 sclk_nxt;
    logic                 cmplt_nxt;
    logic [RES_W-1:0]     res_nxt;

    // Register all state and outputs; SS_n/SCLK return high asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            bcnt      <= '0;
            gap_cnt   <= '0;
            shift     <= '0;
            chnnl_q   <= '0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            cnv_cmplt <= 1'b0;
            res       <= '0;
        end else begin
            state     <= state_nxt;
            div       <= div_nxt;
            bcnt      <= bcnt_nxt;
            gap_cnt   <= gap_nxt;
            shift     <= shift_nxt;
            chnnl_q   <= chnnl_nxt;
            SS_n      <= ss_n_nxt;
            SCLK      <= sclk_nxt;
            MOSI      <= shift_nxt[FRAME_W-1];
            cnv_cmplt <= cmplt_nxt;
            res       <= res_nxt;
        end
    end

    // Next-state and datapath: two frames separated by a chip-select gap
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        bcnt_nxt  = bcnt;
        gap_nxt   = gap_cnt;
        shift_nxt = shift;
        chnnl_nxt = chnnl_q;
        ss_n_nxt  = SS_n;
        cmplt_nxt = cnv_cmplt;
        res_nxt   = res;

        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    chnnl_nxt = chnnl;
                    shift_nxt = {2'b00, chnnl, 11'h000};
                    cmplt_nxt = 1'b0;
                    ss_n_nxt  = 1'b0;
                    div_nxt   = DIV_HALF;
                    bcnt_nxt  = '0;
                    state_nxt = TXN1;
                end
            end
            TXN1, TXN2: begin
                div_nxt = div + DIV_W'(1);
                // SCLK rising edge: capture MISO, present next MOSI bit
                if (div == DIV_RISE && bcnt != BCNT_FULL) begin
                    shift_nxt = {shift[FRAME_W-2:0], MISO};
                    bcnt_nxt  = bcnt + BCNT_W'(1);
                end
                // End of frame before the would-be 17th falling edge
                if (bcnt == BCNT_FULL && div == DIV_MAX) begin
                    ss_n_nxt = 1'b1;
                    if (state == TXN1) begin
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        res_nxt   = shift[RES_W-1:0];
                        state_nxt = DONE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    shift_nxt = {2'b00, chnnl_q, 11'h000};
                    div_nxt   = DIV_HALF;
                    bcnt_nxt  = '0;
                    ss_n_nxt  = 1'b0;
                    state_nxt = TXN2;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            DONE: begin
                cmplt_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        sclk_nxt = ss_n_nxt | div_nxt[DIV_W-1];
    end

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Directed bench for a2d_spi_intf with a behavioural ADC128S-style A2D model.
module tb_a2d_spi_intf;

    localparam int TXN_CLKS = 528;
    localparam int GAP_CLKS = 32;
    localparam int LATENCY  = 1 + TXN_CLKS + GAP_CLKS + TXN_CLKS + 1;
    localparam int MAX_WAIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int checks = 0;
    int errors = 0;

    a2d_spi_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    // ---------------- A2D model ----------------
    logic [11:0] adc_val [8];
    logic [2:0]  addr = 3'd0;
    logic [15:0] miso_frame = 16'h0;
    int          fall_cnt = 0;

    always @(negedge SS_n) begin
        fall_cnt   = 0;
        miso_frame = {4'b0000, adc_val[addr]};
    end

    always @(negedge SCLK) if (!SS_n) fall_cnt = fall_cnt + 1;

    always_comb begin
        MISO = 1'b0;
        if (fall_cnt >= 1 && fall_cnt <= 16) MISO = miso_frame[16 - fall_cnt];
    end

    // ---------------- bus monitor (samples on falling clk) ----------------
    typedef struct {
        int          low;
        int          falls;
        int          rises;
        logic [15:0] frame;
        int          gap;
    } txn_t;

    txn_t        txq[$];
    int          txn_cnt = 0;
    int          cur_low, cur_falls, cur_rises, cur_gap;
    logic [15:0] cur_frame;
    int          high_run = 0;
    int          sclk_err = 0;
    int          cmplt_rises = 0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_cmplt = 1'b0, mosi_hold = 1'b0;

    always @(negedge clk) begin
        if (!SS_n) begin
            if (prev_ss) begin
                cur_low = 0; cur_falls = 0; cur_rises = 0;
                cur_frame = 16'h0; cur_gap = high_run;
                txn_cnt = txn_cnt + 1;
            end
            cur_low = cur_low + 1;
            if (prev_sclk && !SCLK) cur_falls = cur_falls + 1;
            if (!prev_sclk && SCLK) begin
                cur_rises = cur_rises + 1;
                cur_frame = {cur_frame[14:0], mosi_hold};
            end
            mosi_hold = MOSI;
        end else begin
            if (!prev_ss) begin
                txq.push_back('{cur_low, cur_falls, cur_rises, cur_frame, cur_gap});
                addr     = cur_frame[13:11];
                high_run = 0;
            end
            high_run = high_run + 1;
            if (!SCLK) sclk_err = sclk_err + 1;
        end
        if (!prev_cmplt && cnv_cmplt) cmplt_rises = cmplt_rises + 1;
        prev_ss    = SS_n;
        prev_sclk  = SCLK;
        prev_cmplt = cnv_cmplt;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion: optional ignored strt_cnv (chnnl=5) injected mid-TXN1
    task automatic run_conv(input logic [2:0] ch, input logic [11:0] val,
                            input logic [15:0] frame, input bit inject,
                            input logic [11:0] old_res);
        int  lat;
        bit  seen;
        txn_t t;
        adc_val[ch] = val;
        txq.delete();
        txn_cnt     = 0;
        sclk_err    = 0;
        cmplt_rises = 0;
        strt_cnv = 1'b1;
        chnnl    = ch;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < MAX_WAIT) begin
            tick();
            lat = lat + 1;
            if (lat == 1) begin
                strt_cnv = 1'b0;
                chk("cmplt_clear", 32'(cnv_cmplt), 32'd0);
                chk("res_hold", 32'(res), 32'(old_res));
            end
            if (inject && lat == 100) begin
                strt_cnv = 1'b1;
                chnnl    = 3'd5;
            end
            if (inject && lat == 101) strt_cnv = 1'b0;
            if (cnv_cmplt) seen = 1'b1;
        end
        chk("cmplt_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(LATENCY));
        chk("res", 32'(res), 32'(val));
        chk("txn_count", 32'(txq.size()), 32'd2);
        if (txq.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                t = txq[i];
                chk("ss_low_clks", 32'(t.low), 32'(TXN_CLKS));
                chk("sclk_falls", 32'(t.falls), 32'd16);
                chk("sclk_rises", 32'(t.rises), 32'd16);
                chk("mosi_frame", 32'(t.frame), 32'(frame));
            end
            chk("gap_clks", 32'(txq[1].gap), 32'(GAP_CLKS));
        end
        chk("sclk_high_when_idle", 32'(sclk_err), 32'd0);
        repeat (40) tick();
        chk("cmplt_once", 32'(cmplt_rises), 32'd1);
        chk("cmplt_hold", 32'(cnv_cmplt), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
        logic [15:0] frame;
        bit          inject;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          n;
        logic [11:0] last_res;

        vecs[0] = '{3'd3, 12'hABC, 16'h1800, 1'b0};
        vecs[1] = '{3'd1, 12'h001, 16'h0800, 1'b0};
        vecs[2] = '{3'd0, 12'h800, 16'h0000, 1'b0};
        vecs[3] = '{3'd4, 12'hFFF, 16'h2000, 1'b0};
        vecs[4] = '{3'd2, 12'h555, 16'h1000, 1'b1};
        vecs[5] = '{3'd3, 12'hAAA, 16'h1800, 1'b0};
        vecs[6] = '{3'd7, 12'h123, 16'h3800, 1'b0};

        for (int i = 0; i < 8; i++) adc_val[i] = 12'hF0F ^ 12'(i);

        rst_n    = 1'b0;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        #12;
        chk("rst_SS_n", 32'(SS_n), 32'd1);
        chk("rst_SCLK", 32'(SCLK), 32'd1);
        chk("rst_MOSI", 32'(MOSI), 32'd0);
        chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        last_res = 12'h000;
        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].ch, vecs[i].val, vecs[i].frame, vecs[i].inject, last_res);
            last_res = vecs[i].val;
        end

        // Reset asserted during TXN2 bit 7, then a clean conversion
        adc_val[6] = 12'h6E6;
        txq.delete();
        txn_cnt  = 0;
        strt_cnv = 1'b1;
        chnnl    = 3'd6;
        tick();
        strt_cnv = 1'b0;
        n = 0;
        while (!(txn_cnt == 2 && cur_rises == 7) && n < MAX_WAIT) begin
            tick();
            n = n + 1;
        end
        chk("reach_txn2_bit7", 32'(n < MAX_WAIT), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_SS_n", 32'(SS_n), 32'd1);
        chk("midrst_SCLK", 32'(SCLK), 32'd1);
        chk("midrst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("midrst_res", 32'(res), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        run_conv(3'd5, 12'h3C5, 16'h2800, 1'b0, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
